// File: rtl/score_digit_encoder.sv
// Score accumulator (0..SCORE_MAX) with an iterative double-dabble binary-to-BCD converter.
// Optional feature: define SCORE_LEADING_BLANK_EN to blank leading zero digits (value 15).
module score_digit_encoder #(
  parameter int unsigned SCORE_MAX  = 999,
  parameter int unsigned STEP_BASE  = 0,
  parameter int unsigned STEP_PITCH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       add_en,
  input  logic [3:0] add_val,
  output logic [9:0] score,
  output logic [9:0] digit1,
  output logic [9:0] digit2,
  output logic [9:0] digit3,
  output logic [9:0] step1,
  output logic [9:0] step2,
  output logic [9:0] step3,
  output logic       busy,
  output logic       digits_upd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Three BCD nibbles cannot represent more than 999, so the ceiling is clamped there.
  localparam int unsigned SCORE_CEIL = (SCORE_MAX > 999) ? 999 : SCORE_MAX;
  localparam logic [10:0] CEIL_EXT   = 11'(SCORE_CEIL);
  localparam logic [3:0]  LAST_SHIFT = 4'd9;
  localparam logic [3:0]  DIGIT_BLANK = 4'd15;

`ifdef SCORE_LEADING_BLANK_EN
  localparam logic [3:0] RST_HUNDREDS = DIGIT_BLANK;
  localparam logic [3:0] RST_TENS     = DIGIT_BLANK;
`else
  localparam logic [3:0] RST_HUNDREDS = 4'd0;
  localparam logic [3:0] RST_TENS     = 4'd0;
`endif

  // Add-3 correction applied to every nibble that is 5 or more before each shift.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    res = bcd;
    for (int i = 0; i < 3; i++) begin
      if (res[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [9:0]  score_q, score_d;
  logic        dirty_q, dirty_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        upd_q, upd_d;

  logic [10:0] sum_ext;
  logic        score_chg;
  logic [11:0] bcd_adj;
  logic [3:0]  hund_raw, tens_raw;

  // Score update: the sum is formed at 11 bits so 999+15 cannot wrap before the clamp.
  always_comb begin
    sum_ext = {1'b0, score_q} + {7'b0, add_val};
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (add_en) begin
      score_d = (sum_ext > CEIL_EXT) ? CEIL_EXT[9:0] : sum_ext[9:0];
    end
    score_chg = (score_d != score_q);
  end

  // Converter FSM: next state and datapath.
  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    dirty_d  = dirty_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    hund_d   = hund_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    upd_d    = 1'b0;
    bcd_adj  = dabble_adjust(bcd_q);
    hund_raw = bcd_q[11:8];
    tens_raw = bcd_q[7:4];

    unique case (state_q)
      ST_IDLE: begin
        if (dirty_q) begin
          state_d = ST_SHIFT;
          bin_d   = score_q;
          bcd_d   = '0;
          cnt_d   = '0;
          dirty_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[10:0], bin_q[9]};
        bin_d = {bin_q[8:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_SHIFT) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
`ifdef SCORE_LEADING_BLANK_EN
        hund_d = (hund_raw == 4'd0) ? DIGIT_BLANK : hund_raw;
        tens_d = (hund_raw == 4'd0 && tens_raw == 4'd0) ? DIGIT_BLANK : tens_raw;
`else
        hund_d = hund_raw;
        tens_d = tens_raw;
`endif
        ones_d  = bcd_q[3:0];
        upd_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A change arriving mid-conversion (or on the load edge) queues exactly one re-run.
    if (score_chg) dirty_d = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
  // the shift/BCD registers are reset too, keeping the block free of X after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      dirty_q <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hund_q  <= RST_HUNDREDS;
      tens_q  <= RST_TENS;
      ones_q  <= 4'd0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      dirty_q <= dirty_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      upd_q   <= upd_d;
    end
  end

  assign score      = score_q;
  assign digit1     = {6'b0, hund_q};
  assign digit2     = {6'b0, tens_q};
  assign digit3     = {6'b0, ones_q};
  assign step1      = 10'(STEP_BASE);
  assign step2      = 10'(STEP_BASE + STEP_PITCH);
  assign step3      = 10'(STEP_BASE + 2 * STEP_PITCH);
  assign busy       = (state_q != ST_IDLE);
  assign digits_upd = upd_q;

endmodule

// File: tb/tb_score_digit_encoder.sv
// Scoreboard bench for score_digit_encoder: an arithmetic reference model predicts each
// conversion's digits and commit cycle; a monitor checks them when digits_upd fires.
module tb_score_digit_encoder;

  localparam int SCORE_MAX = 999;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clr = 1'b0;
  logic       add_en = 1'b0;
  logic [3:0] add_val = 4'd0;
  logic [9:0] score, digit1, digit2, digit3, step1, step2, step3;
  logic       busy, digits_upd;

  score_digit_encoder #(
    .SCORE_MAX (SCORE_MAX),
    .STEP_BASE (0),
    .STEP_PITCH(4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (clr),
    .add_en    (add_en),
    .add_val   (add_val),
    .score     (score),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .step1     (step1),
    .step2     (step2),
    .step3     (step3),
    .busy      (busy),
    .digits_upd(digits_upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    int         commit_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t digits_of(input int v);
    exp_t e;
    e.h = 4'(v / 100);
    e.t = 4'((v / 10) % 10);
    e.o = 4'(v % 10);
`ifdef SCORE_LEADING_BLANK_EN
    if (e.h == 4'd0) begin
      e.h = 4'd15;
      if (e.t == 4'd0) e.t = 4'd15;
    end
`endif
    e.commit_cyc = 0;
    return e;
  endfunction

  function automatic exp_t reset_digits();
    exp_t e;
`ifdef SCORE_LEADING_BLANK_EN
    e.h = 4'd15;
    e.t = 4'd15;
`else
    e.h = 4'd0;
    e.t = 4'd0;
`endif
    e.o = 4'd0;
    e.commit_cyc = 0;
    return e;
  endfunction

  // Reference model: score arithmetic, a pending flag, and a conversion countdown.
  // A conversion starts one edge after the score changes and commits 11 edges later.
  int m_score = 0;
  bit m_dirty = 1'b0;
  int m_cnt = 0;
  int cyc = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_score = 0;
      m_dirty = 1'b0;
      m_cnt   = 0;
      sb_q.delete();
    end else begin
      int   nxt;
      exp_t e;
      cyc++;
      nxt = m_score;
      if (clr) nxt = 0;
      else if (add_en) nxt = (m_score + int'(add_val) > SCORE_MAX) ? SCORE_MAX
                                                                   : m_score + int'(add_val);
      if (m_cnt > 0) begin
        m_cnt--;
      end else if (m_dirty) begin
        e = digits_of(m_score);
        e.commit_cyc = cyc + 11;
        sb_q.push_back(e);
        m_cnt   = 11;
        m_dirty = 1'b0;
      end
      if (nxt != m_score) m_dirty = 1'b1;
      m_score = nxt;
    end
  end

  // Monitor: pops an expectation whenever the DUT signals a commit (or one is overdue).
  exp_t disp = reset_digits();

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!resetn) begin
      disp = reset_digits();
    end else begin
      check("score", 32'(score), 32'(m_score));
      check("busy", 32'(busy), 32'(m_cnt > 0));
      if (digits_upd) begin
        check("upd_pending", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("commit_cycle", 32'(cyc), 32'(e.commit_cyc));
          disp = e;
        end
      end else if (sb_q.size() > 0 && cyc >= sb_q[0].commit_cyc) begin
        check("digits_upd", 32'(digits_upd), 32'd1);
        disp = sb_q.pop_front();
      end
      check("digit1", 32'(digit1), 32'(disp.h));
      check("digit2", 32'(digit2), 32'(disp.t));
      check("digit3", 32'(digit3), 32'(disp.o));
    end
  end

  task automatic drive(input bit c, input bit a, input logic [3:0] v);
    @(negedge clk);
    clr     = c;
    add_en  = a;
    add_val = v;
  endtask

  task automatic settle();
    int n = 0;
    drive(1'b0, 1'b0, 4'd0);
    while ((m_cnt > 0 || m_dirty || sb_q.size() > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("settle_in_budget", 32'(n < 200), 32'd1);
    @(negedge clk);
  endtask

  task automatic add_up(input int amount);
    int rem = amount;
    while (rem > 0) begin
      drive(1'b0, 1'b1, 4'((rem > 15) ? 15 : rem));
      rem -= (rem > 15) ? 15 : rem;
    end
    settle();
  endtask

  task automatic set_score(input int target);
    drive(1'b1, 1'b0, 4'd0);
    add_up(target);
  endtask

  task automatic check_digits(input string name, input int h, input int t, input int o);
    exp_t e;
    e = digits_of(h * 100 + t * 10 + o);
    check({name, "_d1"}, 32'(digit1), 32'(e.h));
    check({name, "_d2"}, 32'(digit2), 32'(e.t));
    check({name, "_d3"}, 32'(digit3), 32'(e.o));
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    exp_t r;
    r = reset_digits();
    repeat (3) @(negedge clk);
    check("rst_score", 32'(score), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_upd", 32'(digits_upd), 32'd0);
    check("rst_digit1", 32'(digit1), 32'(r.h));
    check("rst_digit2", 32'(digit2), 32'(r.t));
    check("rst_digit3", 32'(digit3), 32'(r.o));
    resetn = 1'b1;
    check("step1", 32'(step1), 32'd0);
    check("step2", 32'(step2), 32'd4);
    check("step3", 32'(step3), 32'd8);

    // First conversion: add 7.
    drive(1'b0, 1'b1, 4'd7);
    settle();
    check_digits("add7", 0, 0, 7);

    // Saturation: 67 x 15 = 1005 clamps to 999; a further add changes nothing.
    drive(1'b1, 1'b0, 4'd0);
    repeat (67) drive(1'b0, 1'b1, 4'd15);
    settle();
    check("sat_score", 32'(score), 32'd999);
    check_digits("sat", 9, 9, 9);
    drive(1'b0, 1'b1, 4'd5);
    settle();
    check("sat_idle", 32'(busy), 32'd0);

    // Add-3 correction in every nibble.
    set_score(123);
    check_digits("s123", 1, 2, 3);
    set_score(100);
    check_digits("s100", 1, 0, 0);
    add_up(5);
    check_digits("s105", 1, 0, 5);
    add_up(45);
    check_digits("s150", 1, 5, 0);

    // Score change mid-conversion: add 3 at edge N, add 4 at edge N+5.
    set_score(0);
    drive(1'b0, 1'b1, 4'd3);
    repeat (4) drive(1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd4);
    settle();
    check_digits("mid", 0, 0, 7);

    // clr wins over add_en.
    set_score(250);
    drive(1'b1, 1'b1, 4'd9);
    settle();
    check("clr_win_score", 32'(score), 32'd0);
    check_digits("clr_win", 0, 0, 0);

    // Asynchronous reset in the middle of a conversion.
    drive(1'b0, 1'b1, 4'd7);
    repeat (6) drive(1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_score", 32'(score), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_upd", 32'(digits_upd), 32'd0);
    check("arst_digit1", 32'(digit1), 32'(r.h));
    check("arst_digit2", 32'(digit2), 32'(r.t));
    check("arst_digit3", 32'(digit3), 32'(r.o));
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 3) drive(1'b1, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
      else if (sel < 65) drive(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      else drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      if ((i % 150) == 149) settle();
    end
    settle();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
